interrupt_dispatcher: RTL and testbench
=======================================

Name: interrupt_dispatcher

Overview:
- Consumer side of the switch interrupt register. It reads the four latched Sw*_State pending flags and applies a per-source mask and a global enable.
- It selects the highest-priority pending source, raises a request to the CPU control unit and presents the handler vector.
- It completes an ack/done handshake with the CPU, then issues a one-cycle clear back to the register so the serviced flag drops.
- It sits between the interrupt register and the processor control FSM.

Parameters:
- ADDR_W, 16, width of the handler vector output.
- VEC_BASE, 16'h0100, vector for source 0.
- VEC_STRIDE, 16'h0010, address step between consecutive sources' vectors.
- ACK_TIMEOUT, 255, cycles to wait in REQ before flagging a missed acknowledge (8-bit counter).

Ports:
- CLK  in  1  system clock, rising edge.
- CLR  in  1  asynchronous, active-low reset.
- Sw_State  in  4  pending flags from the interrupt register; bit0 = Sw0.
- Int_Mask  in  4  1 = source masked (ignored).
- Int_En  in  1  global interrupt enable.
- Int_Ack  in  1  CPU accepts the request (level, sampled on CLK).
- Int_Done  in  1  CPU finished the handler (one-cycle pulse or level).
- Int_Req  out  1  interrupt request to CPU.
- Int_Vector  out  ADDR_W  handler address of the selected source.
- Int_Src  out  2  index of the selected source.
- Busy  out  1  handler in progress.
- Sw_Clr  out  4  one-hot clear to the interrupt register.
- Ack_Missed  out  1  sticky timeout flag.

Behaviour:
- Reset (CLR=0, asynchronous): state=IDLE; Int_Req=0; Int_Vector=VEC_BASE; Int_Src=0; Busy=0; Sw_Clr=0; Ack_Missed=0; counter=0.
- All outputs are registered (Moore, decoded from state and latched index).
- Effective pending: eff = Sw_State & ~Int_Mask.
- Priority: fixed, bit0 highest, bit3 lowest.

IDLE:
- If Int_En=1 and eff!=0: latch idx = lowest set bit of eff.
- Int_Vector <= VEC_BASE + idx*VEC_STRIDE, truncated to ADDR_W. Int_Src <= idx.
- Next state REQ; Int_Req is 1 in the cycle after detection.

REQ:
- Int_Req=1. idx and Int_Vector are frozen; a later higher-priority arrival does not preempt.
- Int_Ack=1: go to SERVICE and clear the counter.
- Otherwise the counter increments. When it reaches ACK_TIMEOUT, set Ack_Missed and stay in REQ with the request held.
- Ack_Missed is cleared only by reset.
- If Int_En drops while in REQ: return to IDLE without clearing the flag, so the source stays pending.

SERVICE:
- Busy=1, Int_Req=0. Wait for Int_Done=1, then go to CLEAR.
- Int_En and Int_Mask changes are ignored here.
- Int_Ack held high is harmless.

CLEAR:
- Exactly one cycle. Sw_Clr = onehot(idx), Busy=1.
- Next state IDLE. The register drops the bit on the edge that ends CLEAR, so IDLE sees the updated flags. This gives no double-dispatch of the same source.

Simultaneous events:
- Int_Ack and Int_Done both high in REQ: Ack is taken; Done is honoured only from SERVICE, so the earliest CLEAR is 2 cycles later.
- Pending flag of the selected source falls while in REQ or SERVICE: the sequence completes normally, and Sw_Clr is still issued (harmless).

Asynchronous reset mid-operation:
- Immediate return to the reset values, with no Sw_Clr pulse. Pending flags remain in the register and are redispatched after reset.

Minimum dispatch-to-redispatch time: IDLE→REQ→SERVICE→CLEAR→IDLE, 4 cycles with immediate Ack and Done.

Test Plan:
- Reset: hold CLR=0 with Sw_State=4'b1111 → all outputs at reset values; Int_Vector=16'h0100. Release CLR; the request appears one cycle after the first edge with Int_En=1.
- Priority: Sw_State=4'b1010, Mask=0, En=1 → Int_Src=1, Int_Vector=16'h0110, Int_Req=1. Ack, then Done → Sw_Clr=4'b0010 for one cycle. Model register clears bit1 → next dispatch Int_Src=3, Int_Vector=16'h0130.
- Masking: Sw_State=4'b0001, Mask=4'b0001 → Int_Req stays 0 for 20 cycles. Unmask → Int_Req=1 the following cycle, Int_Src=0.
- No preemption: dispatch src 2, then raise Sw0 during REQ → Int_Src stays 2 through CLEAR (Sw_Clr=4'b0100). Src 0 is dispatched next.
- Timeout: request src 3, never Ack → Ack_Missed=1 after 255 cycles in REQ, Int_Req still 1. A late Ack proceeds normally and Ack_Missed stays 1.
- Reset mid-SERVICE: assert CLR=0 while Busy=1 → Busy=0 immediately, Sw_Clr never pulses. After release the same source is re-requested.

Source files
------------

// File: rtl/interrupt_dispatcher.sv
// interrupt_dispatcher: masks and prioritises the latched switch flags, hands the vector to the CPU and clears the serviced flag
module interrupt_dispatcher #(
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] VEC_BASE = 'h0100,
  parameter logic [ADDR_W-1:0] VEC_STRIDE = 'h0010,
  parameter logic [7:0] ACK_TIMEOUT = 8'd255
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic [3:0]        Sw_State,
  input  logic [3:0]        Int_Mask,
  input  logic              Int_En,
  input  logic              Int_Ack,
  input  logic              Int_Done,
  output logic              Int_Req,
  output logic [ADDR_W-1:0] Int_Vector,
  output logic [1:0]        Int_Src,
  output logic              Busy,
  output logic [3:0]        Sw_Clr,
  output logic              Ack_Missed
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE, CLEAR} state_t;
  state_t state, state_n;
  logic [1:0] idx, idx_n, low;
  logic [ADDR_W-1:0] vec, vec_n;
  logic [7:0] cnt, cnt_n;
  logic missed, missed_n;
  logic [3:0] eff;
  assign eff = Sw_State & ~Int_Mask;
  assign low = eff[0] ? 2'd0 : eff[1] ? 2'd1 : eff[2] ? 2'd2 : 2'd3;
  // state, latched source and timeout bookkeeping
  always_ff @(posedge CLK or negedge CLR)
    if (!CLR) begin
      state  <= IDLE;
      idx    <= 2'd0;
      vec    <= VEC_BASE;
      cnt    <= 8'd0;
      missed <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      vec    <= vec_n;
      cnt    <= cnt_n;
      missed <= missed_n;
    end
  // dispatch sequencing; selection is frozen once a request is raised
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    vec_n    = vec;
    cnt_n    = cnt;
    missed_n = missed;
    case (state)
      IDLE: begin
        cnt_n = 8'd0;
        if (Int_En && eff != 4'd0) begin
          state_n = REQ;
          idx_n   = low;
          vec_n   = VEC_BASE + VEC_STRIDE * ADDR_W'(low);
        end
      end
      REQ:
        if (Int_Ack) begin
          state_n = SERVICE;
          cnt_n   = 8'd0;
        end else if (!Int_En) state_n = IDLE;
        else if (cnt != ACK_TIMEOUT) begin
          cnt_n    = cnt + 8'd1;
          missed_n = missed | (cnt_n == ACK_TIMEOUT);
        end
      SERVICE: state_n = Int_Done ? CLEAR : SERVICE;
      default: state_n = IDLE;
    endcase
  end
  assign Int_Req    = state == REQ;
  assign Busy       = state == SERVICE || state == CLEAR;
  assign Sw_Clr     = state == CLEAR ? 4'b0001 << idx : 4'b0000;
  assign Int_Vector = vec;
  assign Int_Src    = idx;
  assign Ack_Missed = missed;
endmodule

// File: tb/tb_interrupt_dispatcher.sv
// tb_interrupt_dispatcher: scoreboard bench with a flag-register model and randomized dispatch episodes
module tb_interrupt_dispatcher;
  logic CLK, CLR, Int_En, Int_Ack, Int_Done;
  logic [3:0] Int_Mask, Sw_State, Sw_Clr;
  logic Int_Req, Busy, Ack_Missed;
  logic [15:0] Int_Vector;
  logic [1:0] Int_Src;
  logic [3:0] reg_flags, set_bits, drop_bits, pend;
  logic wipe, req_d, ok;
  logic [17:0] exp_req[$];
  logic [3:0] exp_clr[$];
  int vectors = 0, errors = 0;

  interrupt_dispatcher dut (
    .CLK(CLK), .CLR(CLR), .Sw_State(Sw_State), .Int_Mask(Int_Mask), .Int_En(Int_En),
    .Int_Ack(Int_Ack), .Int_Done(Int_Done), .Int_Req(Int_Req), .Int_Vector(Int_Vector),
    .Int_Src(Int_Src), .Busy(Busy), .Sw_Clr(Sw_Clr), .Ack_Missed(Ack_Missed)
  );

  initial CLK = 0;
  always #5 CLK = ~CLK;

  // external interrupt register: set by stimulus, cleared by Sw_Clr, unaffected by CLR
  always @(posedge CLK) reg_flags <= wipe ? 4'b0 : (reg_flags & ~Sw_Clr & ~drop_bits) | set_bits;
  assign Sw_State = reg_flags;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] lowest(input logic [3:0] f);
    lowest = 2'd0;
    for (int i = 3; i >= 0; i--) if (f[i]) lowest = 2'(i);
  endfunction

  function automatic logic [15:0] vec_of(input logic [1:0] s);
    return 16'h0100 + 16'h0010 * {14'b0, s};
  endfunction

  task automatic push(input logic [1:0] s, input bit with_clr);
    exp_req.push_back({s, vec_of(s)});
    if (with_clr) exp_clr.push_back(4'b0001 << s);
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic raise(input logic [3:0] s);
    set_bits = s; pend |= s; tick(); set_bits = 4'b0;
  endtask

  task automatic drop(input logic [3:0] d);
    drop_bits = d; pend &= ~d; tick(); drop_bits = 4'b0;
  endtask

  task automatic wipe_all();
    wipe = 1; tick(); wipe = 0; pend = 4'b0;
  endtask

  task automatic wait_req(output logic got);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = Int_Req;
    end
    chk("req_seen", got, 1);
  endtask

  task automatic handshake(input int ack_dly, input int done_dly, input bit ack_hold);
    repeat (ack_dly) tick();
    Int_Ack = 1;
    tick();
    chk("svc_busy", Busy, 1);
    chk("svc_req_low", Int_Req, 0);
    if (!ack_hold) Int_Ack = 0;
    repeat (done_dly) begin
      tick();
      Int_Mask = 4'($urandom);
    end
    Int_Done = 1; Int_En = 0;
    tick();
    Int_Done = 0; Int_Ack = 0;
    tick();
    chk("idle_busy", Busy, 0);
  endtask

  // monitor: compares each new request and each clear pulse against the scoreboard
  always @(negedge CLK) begin
    if (!CLR) req_d <= 1'b0;
    else begin
      if (Int_Req && !req_d) begin
        if (exp_req.size() == 0) chk("req_unexpected", 0, 1);
        else begin
          logic [17:0] e;
          e = exp_req.pop_front();
          chk("req_src", Int_Src, e[17:16]);
          chk("req_vec", Int_Vector, e[15:0]);
        end
      end
      req_d <= Int_Req;
    end
    if (Sw_Clr != 4'b0) begin
      if (exp_clr.size() == 0) chk("clr_unexpected", 0, 1);
      else begin
        chk("clr_onehot", Sw_Clr, exp_clr.pop_front());
        chk("clr_busy", Busy, 1);
      end
    end
  end

  initial begin
    logic [3:0] m;
    logic [1:0] s;
    CLR = 0; Int_En = 0; Int_Mask = 0; Int_Ack = 0; Int_Done = 0;
    set_bits = 0; drop_bits = 0; wipe = 1; pend = 0;
    tick(); tick(); wipe = 0;
    raise(4'hf);
    Int_En = 1;
    tick(); tick();
    chk("rst_req", Int_Req, 0);
    chk("rst_vec", Int_Vector, 16'h0100);
    chk("rst_src", Int_Src, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_clr", Sw_Clr, 0);
    chk("rst_missed", Ack_Missed, 0);
    push(2'd0, 1);
    @(negedge CLK); CLR = 1;
    tick();
    chk("first_req", Int_Req, 1);
    handshake(0, 0, 0); pend &= ~4'b0001;

    wipe_all(); raise(4'b1010); Int_Mask = 0; push(2'd1, 1); Int_En = 1;
    wait_req(ok);
    chk("prio_src", Int_Src, 1);
    chk("prio_vec", Int_Vector, 16'h0110);
    Int_Ack = 1; Int_Done = 1;
    tick();
    chk("ackdone_busy", Busy, 1);
    chk("ackdone_noclr", Sw_Clr, 0);
    tick();
    chk("ackdone_clr", Sw_Clr, 4'b0010);
    Int_Ack = 0; Int_Done = 0; Int_En = 0;
    tick();
    chk("clr_one_cycle", Sw_Clr, 0);
    pend &= ~4'b0010;
    chk("flags_after_clr", Sw_State, 4'b1000);
    push(2'd3, 1); Int_En = 1;
    wait_req(ok);
    chk("second_src", Int_Src, 3);
    chk("second_vec", Int_Vector, 16'h0130);
    handshake(1, 1, 1); pend &= ~4'b1000;

    wipe_all(); raise(4'b0001); Int_Mask = 4'b0001; Int_En = 1;
    ok = 0;
    repeat (20) begin tick(); ok |= Int_Req; end
    chk("mask_hold", ok, 0);
    push(2'd0, 1); Int_Mask = 0;
    tick();
    chk("unmask_req", Int_Req, 1);
    chk("unmask_src", Int_Src, 0);
    handshake(0, 0, 0); pend &= ~4'b0001;

    wipe_all(); raise(4'b0100); push(2'd2, 1); Int_En = 1;
    wait_req(ok);
    raise(4'b0001);
    chk("nopreempt_src", Int_Src, 2);
    chk("nopreempt_vec", Int_Vector, 16'h0120);
    handshake(1, 0, 0); pend &= ~4'b0100;
    push(2'd0, 1); Int_En = 1;
    wait_req(ok);
    handshake(0, 0, 0); pend &= ~4'b0001;

    wipe_all(); raise(4'b1000); push(2'd3, 1); Int_En = 1;
    wait_req(ok);
    repeat (254) tick();
    chk("to_early", Ack_Missed, 0);
    tick();
    chk("to_missed", Ack_Missed, 1);
    chk("to_req_held", Int_Req, 1);
    handshake(2, 0, 0); pend &= ~4'b1000;
    chk("to_sticky", Ack_Missed, 1);

    wipe_all(); raise(4'b0100); push(2'd2, 0); Int_En = 1;
    wait_req(ok);
    Int_Ack = 1; tick(); Int_Ack = 0;
    chk("mid_busy", Busy, 1);
    @(negedge CLK); CLR = 0; #1;
    chk("arst_busy", Busy, 0);
    chk("arst_missed", Ack_Missed, 0);
    chk("arst_vec", Int_Vector, 16'h0100);
    repeat (3) tick();
    chk("arst_flag_kept", Sw_State, 4'b0100);
    push(2'd2, 1);
    @(negedge CLK); CLR = 1;
    wait_req(ok);
    handshake(0, 1, 0); pend &= ~4'b0100;

    for (int e = 0; e < 80; e++) begin
      raise(4'($urandom_range(1, 15)));
      m = 4'($urandom);
      if ((pend & ~m) == 4'b0) m = 4'b0;
      chk("flags", Sw_State, pend);
      Int_Mask = m; s = lowest(pend & ~m); push(s, 1); Int_En = 1;
      wait_req(ok);
      if ($urandom_range(0, 1) == 1) raise(4'($urandom));
      if ($urandom_range(0, 3) == 0) drop(4'b0001 << s);
      handshake(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
      pend &= ~(4'b0001 << s);
    end
    repeat (3) tick();
    chk("req_queue_empty", exp_req.size(), 0);
    chk("clr_queue_empty", exp_clr.size(), 0);
    chk("no_false_timeout", Ack_Missed, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
